// File: rtl/input_steer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the input_steer block: state encoding and default
// parameter values used by the interface and the top module.
package input_steer_pkg;

  localparam int DATA_W_DEF    = 10;
  localparam int CNT_W_DEF     = 8;
  localparam int STALL_MAX_DEF = 16;

  // Bit of the word that selects the destination FIFO.
  localparam int CLASS_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // Counter width able to represent 0..maxVal inclusive.
  function automatic int stallWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/input_steer_if.sv
`timescale 1ns/1ps
// Link-side handshake and two-FIFO write side of input_steer as one bundle.
// The slave modport is the steering block; master is whatever surrounds it.
interface input_steer_if #(
  parameter int DATA_W = input_steer_pkg::DATA_W_DEF,
  parameter int CNT_W  = input_steer_pkg::CNT_W_DEF
) ();

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  logic              full0;
  logic              full1;
  logic              almost_full0;
  logic              almost_full1;

  logic              push0;
  logic              push1;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;

  logic              pause;
  logic              error;

  modport slave (
    input  data_in, valid_in,
    input  full0, full1, almost_full0, almost_full1,
    output ready_out,
    output push0, push1, data_out0, data_out1,
    output count0, count1,
    output pause, error
  );

  modport master (
    output data_in, valid_in,
    output full0, full1, almost_full0, almost_full1,
    input  ready_out,
    input  push0, push1, data_out0, data_out1,
    input  count0, count1,
    input  pause, error
  );

endinterface

// File: rtl/input_steer.sv
`timescale 1ns/1ps
// Steers words from a valid/ready link into one of two downstream FIFOs by
// class bit, with a one-word holding register, flow-control pause and a sticky stall error.
module input_steer
  import input_steer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input_steer_if.slave bus
);

  localparam int                 STALL_W     = stallWidth(STALL_MAX);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_valid_q, hold_valid_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]    count0_q, count0_d;
  logic [CNT_W-1:0]    count1_q, count1_d;

  logic target;
  logic push0;
  logic push1;
  logic ready;
  logic accept;
  logic stall_hit;
  logic any_almost_full;

  assign target          = hold_data_q[CLASS_BIT];
  assign any_almost_full = bus.almost_full0 || bus.almost_full1;

  // Pushes come only from registered state and the live full flags, so a
  // full FIFO can never be written even in the cycle it becomes full.
  always_comb begin
    push0  = 1'b0;
    push1  = 1'b0;
    ready  = 1'b0;
    accept = 1'b0;
    if (hold_valid_q && (state_q != ST_ERROR)) begin
      push0 = !target && !bus.full0;
      push1 =  target && !bus.full1;
    end
    ready  = (state_q == ST_ACTIVE) && (!hold_valid_q || push0 || push1);
    accept = bus.valid_in && ready;
  end

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    stall_d      = stall_q;
    count0_d     = count0_q;
    count1_d     = count1_q;
    if (state_q != ST_ERROR) begin
      if (accept) begin
        hold_data_d  = bus.data_in;
        hold_valid_d = 1'b1;
      end else if (push0 || push1) begin
        hold_valid_d = 1'b0;
      end
      if (hold_valid_q && !push0 && !push1) begin
        stall_d = stall_q + STALL_W'(1);
      end else begin
        stall_d = '0;
      end
    end
    if (push0) begin
      count0_d = count0_q + CNT_W'(1);
    end
    if (push1) begin
      count1_d = count1_q + CNT_W'(1);
    end
  end

  // The stall limit is judged on the value the counter is about to take, and
  // it overrides any pause/resume decision made in the same cycle.
  assign stall_hit = (state_q != ST_ERROR) && (stall_d == STALL_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (stall_hit) begin
          state_d = ST_ERROR;
        end else if (any_almost_full) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stall_hit) begin
          state_d = ST_ERROR;
        end else if (!any_almost_full) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      stall_q      <= '0;
      count0_q     <= '0;
      count1_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      stall_q      <= stall_d;
      count0_q     <= count0_d;
      count1_q     <= count1_d;
    end
  end

  assign bus.ready_out = ready;
  assign bus.push0     = push0;
  assign bus.push1     = push1;
  assign bus.data_out0 = target ? '0 : hold_data_q;
  assign bus.data_out1 = target ? hold_data_q : '0;
  assign bus.count0    = count0_q;
  assign bus.count1    = count1_q;
  assign bus.pause     = (state_q == ST_PAUSE);
  assign bus.error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_input_steer.sv
`timescale 1ns/1ps
// Scoreboard bench for input_steer: accepted words queue their expected FIFO
// write, and an independent monitor matches every push against that queue.
module tb_input_steer;
  import input_steer_pkg::*;

  typedef struct {
    logic       fifo;
    logic [9:0] data;
  } expItem_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  input_steer_if bus ();

  input_steer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  expItem_t   expQ[$];
  expItem_t   monItem;
  int         checks = 0;
  int         errors = 0;
  int         modelCount0 = 0;
  int         modelCount1 = 0;
  int         acceptCount = 0;

  logic       sReady, sPush0, sPush1, sPause, sError, accepted, prevAf;
  logic [9:0] sData0, sData1;
  logic [7:0] sCount0, sCount1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive at +2 after the rising edge, sample at the falling
  // edge, and record an expected FIFO write if the word was handed over.
  task automatic applyStimulus(input logic v, input logic [9:0] d,
                               input logic f0, input logic f1,
                               input logic af0, input logic af1);
    expItem_t it;
    @(posedge clk);
    #2;
    bus.valid_in     = v;
    bus.data_in      = d;
    bus.full0        = f0;
    bus.full1        = f1;
    bus.almost_full0 = af0;
    bus.almost_full1 = af1;
    @(negedge clk);
    sReady  = bus.ready_out;
    sPush0  = bus.push0;
    sPush1  = bus.push1;
    sPause  = bus.pause;
    sError  = bus.error;
    sData0  = bus.data_out0;
    sData1  = bus.data_out1;
    sCount0 = bus.count0;
    sCount1 = bus.count1;
    #1;
    accepted = v && sReady;
    if (accepted) begin
      it.fifo = d[CLASS_BIT];
      it.data = d;
      expQ.push_back(it);
      acceptCount++;
    end
  endtask

  // Any word still held when reset falls is lost, so its expectation goes too.
  task automatic resetDut();
    @(posedge clk);
    #2;
    reset = 1'b0;
    expQ.delete();
    modelCount0 = 0;
    modelCount1 = 0;
    #1;
    checkOutput("rst ready_out", 32'(bus.ready_out), 0);
    checkOutput("rst push0", 32'(bus.push0), 0);
    checkOutput("rst push1", 32'(bus.push1), 0);
    checkOutput("rst pause", 32'(bus.pause), 0);
    checkOutput("rst error", 32'(bus.error), 0);
    checkOutput("rst data_out0", 32'(bus.data_out0), 0);
    checkOutput("rst data_out1", 32'(bus.data_out1), 0);
    checkOutput("rst count0", 32'(bus.count0), 0);
    checkOutput("rst count1", 32'(bus.count1), 0);
    bus.valid_in     = 1'b0;
    bus.data_in      = '0;
    bus.full0        = 1'b0;
    bus.full1        = 1'b0;
    bus.almost_full0 = 1'b0;
    bus.almost_full1 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle ready_out", 32'(bus.ready_out), 0);
    checkOutput("idle pause", 32'(bus.pause), 0);
  endtask

  // Every FIFO write must be the oldest outstanding accepted word, to the FIFO
  // its class bit names, and never to a FIFO flagged full.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.push0 || bus.push1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected push: push0=%0b push1=%0b, expected no push", bus.push0, bus.push1);
        end else begin
          monItem = expQ.pop_front();
          if (monItem.fifo) modelCount1++;
          else modelCount0++;
          checkOutput("single push", 32'(bus.push0 && bus.push1), 0);
          checkOutput("push target", 32'(bus.push1), 32'(monItem.fifo));
          checkOutput("push data", monItem.fifo ? 32'(bus.data_out1) : 32'(bus.data_out0), 32'(monItem.data));
        end
      end
      checkOutput("push0 vs full0", 32'(bus.push0 && bus.full0), 0);
      checkOutput("push1 vs full1", 32'(bus.push1 && bus.full1), 0);
    end
  end

  initial begin
    bus.valid_in     = 1'b0;
    bus.data_in      = '0;
    bus.full0        = 1'b0;
    bus.full1        = 1'b0;
    bus.almost_full0 = 1'b0;
    bus.almost_full1 = 1'b0;
    resetDut();

    // Three back-to-back words alternating class, one cycle latency each.
    applyStimulus(1'b1, 10'h005, 0, 0, 0, 0);
    checkOutput("b2b accept 1", 32'(accepted), 1);
    applyStimulus(1'b1, 10'h105, 0, 0, 0, 0);
    checkOutput("b2b accept 2", 32'(accepted), 1);
    checkOutput("latency push0", 32'(sPush0), 1);
    applyStimulus(1'b1, 10'h00A, 0, 0, 0, 0);
    checkOutput("b2b accept 3", 32'(accepted), 1);
    checkOutput("latency push1", 32'(sPush1), 1);
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("third push0", 32'(sPush0), 1);
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("count0 after three", 32'(sCount0), 2);
    checkOutput("count1 after three", 32'(sCount1), 1);

    // FIFO 1 full for five cycles with a class-1 word held.
    applyStimulus(1'b1, 10'h1FF, 0, 1, 0, 0);
    checkOutput("full1 accept", 32'(accepted), 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 10'h000, 0, 1, 0, 0);
      checkOutput("full1 no push", 32'(sPush1), 0);
      checkOutput("full1 ready_out", 32'(sReady), 0);
    end
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("full1 release push", 32'(sPush1), 1);
    checkOutput("full1 release data", 32'(sData1), 32'h1FF);
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("short stall error", 32'(sError), 0);

    // almost_full0 pulse: pause follows it one cycle later, hold still drains.
    prevAf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 10'h020 + 10'(i), 0, 0, (i < 3), 0);
      checkOutput("pause flag", 32'(sPause), 32'(prevAf));
      checkOutput("pause ready_out", 32'(sReady), 32'(!prevAf));
      prevAf = (i < 3);
    end
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("count0 model", 32'(sCount0), 32'(8'(modelCount0)));
    checkOutput("count1 model", 32'(sCount1), 32'(8'(modelCount1)));

    // 256 class-0 pushes wrap count0.
    resetDut();
    acceptCount = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, {1'($urandom), 1'b0, 8'(i)}, 0, 0, 0, 0);
    end
    checkOutput("wrap accepts", 32'(acceptCount), 256);
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("count0 pre-wrap", 32'(sCount0), 32'hFF);
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("count0 wrapped", 32'(sCount0), 0);
    checkOutput("count1 after wrap", 32'(sCount1), 0);

    // Reset with a word held: it is dropped and outputs clear immediately.
    applyStimulus(1'b1, 10'h1AB, 0, 0, 0, 0);
    applyStimulus(1'b1, 10'h0C7, 1, 0, 0, 0);
    checkOutput("held accept", 32'(accepted), 1);
    applyStimulus(1'b0, 10'h000, 1, 0, 0, 0);
    checkOutput("held data_out0", 32'(sData0), 32'h0C7);
    checkOutput("held no push", 32'(sPush0), 0);
    resetDut();
    repeat (3) applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);

    // Stall to error: 16 blocked cycles, then error is permanent.
    applyStimulus(1'b1, 10'h033, 1, 0, 0, 0);
    checkOutput("stall accept", 32'(accepted), 1);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 10'h044, 1, 0, 0, 0);
      checkOutput("stall error", 32'(sError), 32'(i >= STALL_MAX_DEF + 1));
      checkOutput("stall ready_out", 32'(sReady), 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
      checkOutput("error no push", 32'(sPush0), 0);
      checkOutput("error sticky", 32'(sError), 1);
    end
    resetDut();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 10'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
      applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    end
    applyStimulus(1'b0, 10'h000, 0, 0, 0, 0);
    checkOutput("random drain", 32'(expQ.size()), 0);
    checkOutput("random count0", 32'(sCount0), 32'(8'(modelCount0)));
    checkOutput("random count1", 32'(sCount1), 32'(8'(modelCount1)));
    checkOutput("random error", 32'(sError), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
